// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the accumulator CPU: opcode width, opcode codes
// and a helper that pulls the opcode field out of an instruction word.
// Used by the program memory loader to spot the HLT word that ends a session.
package cpu_isa_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] HLT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] STO  = 5'b00001;
  localparam logic [OPCODE_W-1:0] LD   = 5'b00010;
  localparam logic [OPCODE_W-1:0] LDI  = 5'b00011;
  localparam logic [OPCODE_W-1:0] ADD  = 5'b00100;
  localparam logic [OPCODE_W-1:0] ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] SUB  = 5'b00110;
  localparam logic [OPCODE_W-1:0] SUBI = 5'b00111;

  // Opcode is the top OPCODE_W bits of a word that is `width` bits wide,
  // passed zero-extended to 32 bits.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] word,
                                                    input int unsigned width);
    return OPCODE_W'(word >> (width - OPCODE_W));
  endfunction

endpackage

// File: rtl/prog_mem_boot_if.sv
// Bundle of the loader byte stream and the CPU fetch port of prog_mem_boot.
// master = the side driving bytes/fetches (UART bridge + CPU), slave = memory.
// Signals keep their established names so existing CPU code connects unchanged.
interface prog_mem_boot_if #(
  parameter int ADDR_BUS  = 11,
  parameter int DATA_SIZE = 16
);
  logic                 Load_Start;
  logic [7:0]           Byte_In;
  logic                 Byte_Valid;
  logic                 Byte_Ready;
  logic                 Loading;
  logic                 Load_Done;
  logic [ADDR_BUS:0]    Load_Count;
  logic                 Fetch_En;
  logic [ADDR_BUS-1:0]  Addr;
  logic [DATA_SIZE-1:0] Data;
  logic                 Data_Valid;

  modport master (
    output Load_Start, Byte_In, Byte_Valid, Fetch_En, Addr,
    input  Byte_Ready, Loading, Load_Done, Load_Count, Data, Data_Valid
  );

  modport slave (
    input  Load_Start, Byte_In, Byte_Valid, Fetch_En, Addr,
    output Byte_Ready, Loading, Load_Done, Load_Count, Data, Data_Valid
  );
endinterface

// File: rtl/prog_mem_boot_ram.sv
// Program storage: one synchronous write port, one registered read port.
// Read latency 1 cycle; read register clears on reset, array contents do not.
// No backpressure; caller guarantees reads and writes never target the same cycle.
module prog_mem_ram #(
  parameter int ADDR_BUS  = 11,
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [ADDR_BUS-1:0]  waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BUS-1:0]  raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  logic [DATA_SIZE-1:0] mem_q [2**ADDR_BUS];
  logic [DATA_SIZE-1:0] rdata_q;

  // Write port: the array is never reset so loaded words survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read: holds its value when no read is requested.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_boot.sv
// Loadable program memory: byte-serial MSB-first loader plus registered CPU fetch.
// Fetch latency 1 cycle; loader writes a word on the edge accepting its last byte.
// Byte_Ready is high for the whole LOAD state; fetches are ignored while loading.
module prog_mem_boot
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_BUS  = 11,
  parameter int DATA_SIZE = 16
) (
  input logic              Clk,
  input logic              Reset,
  prog_mem_boot_if.slave   bus
);

  localparam int BPW   = DATA_SIZE / 8;
  localparam int ASM_W = (DATA_SIZE > 8) ? DATA_SIZE - 8 : 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [ASM_W-1:0]     asm_q, asm_d;
  logic [ADDR_BUS-1:0]  ptr_q, ptr_d;
  logic [ADDR_BUS:0]    cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 dvld_q;

  logic                 byte_acc;
  logic                 last_byte;
  logic                 we;
  logic                 re;
  logic [DATA_SIZE-1:0] word;

  assign byte_acc  = (state_q == ST_LOAD) && bus.Byte_Valid;
  assign last_byte = (bcnt_q == 2'(BPW - 1));
  // Older bytes sit in the upper part of the assembly register; the newest
  // byte lands in the low 8 bits, so the first byte ends up most significant.
  assign word      = DATA_SIZE'({asm_q, bus.Byte_In});
  assign re        = (state_q == ST_RUN) && bus.Fetch_En;

  // Loader FSM: session start, byte assembly, word write and termination.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.Load_Start) begin
          state_d = ST_LOAD;
          bcnt_d  = '0;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        if (byte_acc) begin
          asm_d = ASM_W'(word);
          if (last_byte) begin
            we     = 1'b1;
            bcnt_d = '0;
            cnt_d  = cnt_q + 1'b1;
            // Stop on HLT or on the last address; the pointer never wraps.
            if (opcode_of(32'(word), DATA_SIZE) == HLT || ptr_q == {ADDR_BUS{1'b1}}) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Loader state registers; reset aborts any session without a done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      bcnt_q  <= '0;
      asm_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Data_Valid marks that Data was refreshed by the previous cycle's fetch.
  always_ff @(posedge Clk) begin
    if (Reset) dvld_q <= 1'b0;
    else       dvld_q <= re;
  end

  prog_mem_ram #(
    .ADDR_BUS  (ADDR_BUS),
    .DATA_SIZE (DATA_SIZE)
  ) u_ram (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (word),
    .re_i    (re),
    .raddr_i (bus.Addr),
    .rdata_o (bus.Data)
  );

  assign bus.Byte_Ready = (state_q == ST_LOAD);
  assign bus.Loading    = (state_q == ST_LOAD);
  assign bus.Load_Done  = done_q;
  assign bus.Load_Count = cnt_q;
  assign bus.Data_Valid = dvld_q;

endmodule

// File: tb/tb_prog_mem_boot.sv
// Self-checking bench for prog_mem_boot with an 8-word memory (ADDR_BUS=3).
// Fetch results are checked through a scoreboard queue; loader flags are
// checked directly after each clock edge.
module tb_prog_mem_boot;

  localparam int AB = 3;
  localparam int DS = 16;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  prog_mem_boot_if #(.ADDR_BUS(AB), .DATA_SIZE(DS)) bus ();

  prog_mem_boot #(.ADDR_BUS(AB), .DATA_SIZE(DS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [DS-1:0] exp_mem [2**AB];
  logic [DS-1:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input int a);
    bus.Fetch_En = 1'b1;
    bus.Addr     = AB'(a);
    sb_q.push_back(exp_mem[a]);
    step();
    bus.Fetch_En = 1'b0;
  endtask

  task automatic start_load();
    bus.Load_Start = 1'b1;
    step();
    bus.Load_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.Byte_Valid = 1'b1;
    bus.Byte_In    = b;
    step();
    bus.Byte_Valid = 1'b0;
  endtask

  // Fetch monitor: every Data_Valid must match the oldest outstanding fetch.
  initial begin
    forever begin
      @(negedge Clk);
      if (bus.Data_Valid === 1'b1) begin
        if (sb_q.size() == 0) chk("dv_unexpected", 1, 0);
        else                  chk("fetch_data", 32'(bus.Data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DS-1:0] full_w [8];
    for (int i = 0; i < 2**AB; i++) exp_mem[i] = '0;
    Reset          = 1'b1;
    bus.Load_Start = 1'b0;
    bus.Byte_In    = '0;
    bus.Byte_Valid = 1'b0;
    bus.Fetch_En   = 1'b0;
    bus.Addr       = '0;

    // Reset state.
    step();
    step();
    chk("rst_data",   32'(bus.Data), 0);
    chk("rst_dv",     32'(bus.Data_Valid), 0);
    chk("rst_rdy",    32'(bus.Byte_Ready), 0);
    chk("rst_loading",32'(bus.Loading), 0);
    chk("rst_done",   32'(bus.Load_Done), 0);
    chk("rst_count",  32'(bus.Load_Count), 0);
    Reset = 1'b0;
    step();
    for (int a = 0; a < 4; a++) fetch(a);
    step();

    // Load terminated by HLT, bytes back-to-back.
    start_load();
    chk("hlt_loading", 32'(bus.Loading), 1);
    chk("hlt_rdy",     32'(bus.Byte_Ready), 1);
    chk("hlt_count0",  32'(bus.Load_Count), 0);
    send_byte(8'h18); send_byte(8'h10);
    send_byte(8'h08); send_byte(8'h01);
    send_byte(8'h00);
    chk("hlt_not_done", 32'(bus.Load_Done), 0);
    send_byte(8'h00);
    chk("hlt_done",     32'(bus.Load_Done), 1);
    chk("hlt_loading0", 32'(bus.Loading), 0);
    chk("hlt_count",    32'(bus.Load_Count), 3);
    exp_mem[0] = 16'h1810; exp_mem[1] = 16'h0801; exp_mem[2] = 16'h0000;
    fetch(0);
    chk("hlt_done_fall", 32'(bus.Load_Done), 0);
    fetch(1);
    fetch(2);
    step();

    // Gapped loader bytes: a byte every other cycle, Byte_Ready must stay up.
    start_load();
    begin
      logic [7:0] gb [4];
      gb = '{8'h0A, 8'h55, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin
        chk("gap_rdy_v", 32'(bus.Byte_Ready), 1);
        send_byte(gb[i]);
        if (i != 3) begin
          chk("gap_rdy_idle", 32'(bus.Byte_Ready), 1);
          step();
        end
      end
    end
    chk("gap_done",  32'(bus.Load_Done), 1);
    chk("gap_count", 32'(bus.Load_Count), 2);
    exp_mem[0] = 16'h0A55; exp_mem[1] = 16'h0000;
    fetch(0);
    fetch(1);
    step();

    // Full memory: 8 non-HLT words end the session at the last address.
    start_load();
    for (int i = 0; i < 8; i++) begin
      full_w[i] = 16'h0800 + 16'(i * 16'h0111);
      send_byte(full_w[i][15:8]);
      send_byte(full_w[i][7:0]);
      if (i == 6) chk("full_still_loading", 32'(bus.Loading), 1);
    end
    chk("full_done",    32'(bus.Load_Done), 1);
    chk("full_loading", 32'(bus.Loading), 0);
    chk("full_count",   32'(bus.Load_Count), 8);
    for (int i = 0; i < 8; i++) exp_mem[i] = full_w[i];
    bus.Byte_Valid = 1'b1;
    bus.Byte_In    = 8'hFF;
    chk("full_rdy_after", 32'(bus.Byte_Ready), 0);
    step();
    bus.Byte_Valid = 1'b0;
    chk("full_ignored_byte", 32'(bus.Loading), 0);
    fetch(0);
    fetch(7);
    step();

    // Reset mid-load after 1.5 words.
    start_load();
    send_byte(8'h0B); send_byte(8'hCD);
    send_byte(8'h0E);
    Reset = 1'b1;
    step();
    chk("mid_loading", 32'(bus.Loading), 0);
    chk("mid_count",   32'(bus.Load_Count), 0);
    chk("mid_done",    32'(bus.Load_Done), 0);
    Reset = 1'b0;
    step();
    chk("mid_done_after", 32'(bus.Load_Done), 0);
    chk("mid_rdy",        32'(bus.Byte_Ready), 0);
    exp_mem[0] = 16'h0BCD;
    fetch(0);
    fetch(1);
    step();

    // Simultaneous Load_Start and Fetch_En, then fetches held during LOAD.
    bus.Load_Start = 1'b1;
    bus.Fetch_En   = 1'b1;
    bus.Addr       = '0;
    sb_q.push_back(exp_mem[0]);
    step();
    bus.Load_Start = 1'b0;
    chk("sim_loading", 32'(bus.Loading), 1);
    step();
    chk("sim_dv_load",   32'(bus.Data_Valid), 0);
    chk("sim_data_hold", 32'(bus.Data), 32'(16'h0BCD));
    bus.Fetch_En = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    chk("sim_done",  32'(bus.Load_Done), 1);
    chk("sim_count", 32'(bus.Load_Count), 1);
    exp_mem[0] = 16'h0000;
    fetch(0);
    fetch(1);
    step();
    step();

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
